pocket_event_arbiter: RTL and testbench

Upstream stage of the score counter: turns per-ball pocket collision levels from the drawing/collision logic into clean, single-cycle `increaseScore` / `decreaseScore` pulses. Each ball's pocket flag is accumulated over a video frame and committed at the frame boundary. Pending events are issued one at a time, lowest ball index first. Each object ball scores exactly once per game; the white ball is re-armed after it leaves the pocket.

---
 rtl/pocket_event_arbiter_if.sv | 36 +++
 rtl/pocket_event_arbiter.sv | 140 ++++++++++++++
 tb/tb_pocket_event_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pocket_event_arbiter_if.sv
// Event bus between the collision logic / score counter and pocket_event_arbiter.
// The master drives the frame and pocket inputs, and the slave returns the score pulses and state.
interface pocket_event_arbiter_if #(
   parameter int NUM_BALLS = 8
);
   logic                 startOfFrame;
   logic                 newGame;
   logic [NUM_BALLS-1:0] ballInPocket;
   logic                 increaseScore;
   logic                 decreaseScore;
   logic                 whiteBallRespawn;
   logic [NUM_BALLS-1:0] pocketedMask;
   logic                 allPocketed;

   modport master (
      output startOfFrame,
      output newGame,
      output ballInPocket,
      input  increaseScore,
      input  decreaseScore,
      input  whiteBallRespawn,
      input  pocketedMask,
      input  allPocketed
   );

   modport slave (
      input  startOfFrame,
      input  newGame,
      input  ballInPocket,
      output increaseScore,
      output decreaseScore,
      output whiteBallRespawn,
      output pocketedMask,
      output allPocketed
   );
endinterface

// File: rtl/pocket_event_arbiter.sv
// Turns per-ball pocket levels into per-frame committed, one-at-a-time score pulses.
// Optional SCORE_FOUL_PENALTY_EN: a white-ball event also pulses decreaseScore.
module pocket_event_arbiter #(
   parameter int NUM_BALLS = 8
) (
   input  logic                   clk,
   input  logic                   resetN,
   pocket_event_arbiter_if.slave  evt
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_GAP  = 1'b1
   } state_t;

   // Object balls occupy bits 1..NUM_BALLS-1. Bit 0 is the white ball.
   localparam logic [NUM_BALLS-1:0] OBJ_MASK = {{(NUM_BALLS-1){1'b1}}, 1'b0};
   localparam logic [NUM_BALLS-1:0] ONE      = NUM_BALLS'(1);

   state_t               state_q, state_d;
   logic [NUM_BALLS-1:0] hit_frame_q, hit_frame_d;
   logic [NUM_BALLS-1:0] pending_q, pending_d;
   logic [NUM_BALLS-1:0] pocketed_q, pocketed_d;
   logic                 white_armed_q, white_armed_d;
   logic                 inc_q, inc_d;
   logic                 resp_q, resp_d;
   logic                 all_q, all_d;

   logic [NUM_BALLS-1:0] new_events;
   logic [NUM_BALLS-1:0] candidates;
   logic [NUM_BALLS-1:0] issue_onehot;

`ifdef SCORE_FOUL_PENALTY_EN
   logic                 dec_q, dec_d;
`endif

   always_comb begin
      hit_frame_d   = evt.startOfFrame ? evt.ballInPocket : (hit_frame_q | evt.ballInPocket);
      new_events    = '0;
      pocketed_d    = pocketed_q;
      white_armed_d = white_armed_q;

      // Commit of the frame that just ended, using the accumulated flags.
      if (evt.startOfFrame) begin
         new_events    = (hit_frame_q & ~pocketed_q & OBJ_MASK)
                       | {{(NUM_BALLS-1){1'b0}}, hit_frame_q[0] & white_armed_q};
         pocketed_d    = pocketed_q | (new_events & OBJ_MASK);
         white_armed_d = ~hit_frame_q[0];
      end

      // Commit and issue merge, so a fresh event can go out on the very next cycle.
      candidates   = pending_q | new_events;
      issue_onehot = candidates & ((~candidates) + ONE);

      state_d   = state_q;
      pending_d = candidates;
      inc_d     = 1'b0;
      resp_d    = 1'b0;
`ifdef SCORE_FOUL_PENALTY_EN
      dec_d     = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (candidates != '0) begin
               pending_d = candidates & ~issue_onehot;
               resp_d    = issue_onehot[0];
               inc_d     = |(issue_onehot & OBJ_MASK);
`ifdef SCORE_FOUL_PENALTY_EN
               dec_d     = issue_onehot[0];
`endif
               state_d   = ST_GAP;
            end
         end
         ST_GAP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (evt.newGame) begin
         hit_frame_d   = '0;
         pending_d     = '0;
         pocketed_d    = '0;
         white_armed_d = 1'b1;
         state_d       = ST_IDLE;
         inc_d         = 1'b0;
         resp_d        = 1'b0;
`ifdef SCORE_FOUL_PENALTY_EN
         dec_d         = 1'b0;
`endif
      end

      all_d = &pocketed_d[NUM_BALLS-1:1];
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q       <= ST_IDLE;
         hit_frame_q   <= '0;
         pending_q     <= '0;
         pocketed_q    <= '0;
         white_armed_q <= 1'b1;
         inc_q         <= 1'b0;
         resp_q        <= 1'b0;
         all_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         hit_frame_q   <= hit_frame_d;
         pending_q     <= pending_d;
         pocketed_q    <= pocketed_d;
         white_armed_q <= white_armed_d;
         inc_q         <= inc_d;
         resp_q        <= resp_d;
         all_q         <= all_d;
      end
   end

`ifdef SCORE_FOUL_PENALTY_EN
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         dec_q <= 1'b0;
      end else begin
         dec_q <= dec_d;
      end
   end
   assign evt.decreaseScore = dec_q;
`else
   // The white ball never affects the score in this build.
   assign evt.decreaseScore = 1'b0;
`endif

   assign evt.increaseScore    = inc_q;
   assign evt.whiteBallRespawn = resp_q;
   assign evt.pocketedMask     = pocketed_q;
   assign evt.allPocketed      = all_q;

endmodule

// File: tb/tb_pocket_event_arbiter.sv
// Self-checking bench for pocket_event_arbiter: directed scenarios plus random traffic
// compared every cycle against a frame/event-level reference model.
module tb_pocket_event_arbiter;
   localparam int N = 8;
`ifdef SCORE_FOUL_PENALTY_EN
   localparam bit PEN = 1'b1;
`else
   localparam bit PEN = 1'b0;
`endif

   logic clk = 1'b0;
   logic resetN = 1'b0;
   always #5 clk = ~clk;

   pocket_event_arbiter_if #(.NUM_BALLS(N)) bus();
   pocket_event_arbiter #(.NUM_BALLS(N)) dut (.clk(clk), .resetN(resetN), .evt(bus));

   int n_chk = 0;
   int n_pass = 0;

   // Reference model state: frame flags, scored set, pending event set, last issue cycle.
   bit [N-1:0] m_hit, m_pend, m_pocketed;
   bit         m_armed;
   int         cyc = 0;
   int         m_last;
   logic       e_inc, e_dec, e_resp, e_all;
   logic [N-1:0] e_mask;

   task automatic model_reset();
      m_hit = '0; m_pend = '0; m_pocketed = '0; m_armed = 1'b1; m_last = -10;
      e_inc = 0; e_dec = 0; e_resp = 0; e_all = 0; e_mask = '0;
   endtask

   task automatic model_step(input bit sof, input bit ng, input bit [N-1:0] bip);
      bit [N-1:0] nw;
      int k;
      cyc++;
      if (!resetN || ng) begin
         model_reset();
         return;
      end
      e_inc = 0; e_dec = 0; e_resp = 0;
      nw = '0;
      if (sof) begin
         for (int i = 1; i < N; i++) if (m_hit[i] && !m_pocketed[i]) nw[i] = 1'b1;
         if (m_hit[0]) begin
            if (m_armed) nw[0] = 1'b1;
            m_armed = 1'b0;
         end else begin
            m_armed = 1'b1;
         end
         for (int i = 1; i < N; i++) if (nw[i]) m_pocketed[i] = 1'b1;
      end
      m_pend = m_pend | nw;
      if (m_pend != '0 && (cyc - m_last) >= 2) begin
         k = -1;
         for (int i = N - 1; i >= 0; i--) if (m_pend[i]) k = i;
         m_pend[k] = 1'b0;
         m_last = cyc;
         if (k == 0) begin
            e_resp = 1'b1;
            e_dec  = PEN;
         end else begin
            e_inc = 1'b1;
         end
      end
      m_hit = sof ? bip : (m_hit | bip);
      e_mask = m_pocketed;
      e_all = &m_pocketed[N-1:1];
   endtask

   task automatic tick(input bit sof, input bit ng, input bit [N-1:0] bip);
      bus.startOfFrame = sof;
      bus.newGame      = ng;
      bus.ballInPocket = bip;
      model_step(sof, ng, bip);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.startOfFrame = 0; bus.newGame = 0; bus.ballInPocket = '0;
      repeat (2) @(posedge clk);
      #1;
      if ({bus.increaseScore, bus.decreaseScore, bus.whiteBallRespawn, bus.allPocketed, bus.pocketedMask} !== 12'h000)
         $display("FAIL reset_outputs got=%b exp=0", {bus.increaseScore, bus.decreaseScore, bus.whiteBallRespawn, bus.allPocketed, bus.pocketedMask});
      else n_pass++;
      n_chk++;
      resetN = 1'b1;
      model_reset();
      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < 20; c++) begin
            tick(c == 0, 0, '0);
            if ({bus.increaseScore, bus.decreaseScore, bus.whiteBallRespawn, bus.allPocketed, bus.pocketedMask} !== {e_inc, e_dec, e_resp, e_all, e_mask})
               $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, {bus.increaseScore, bus.decreaseScore, bus.whiteBallRespawn, bus.allPocketed, bus.pocketedMask}, {e_inc, e_dec, e_resp, e_all, e_mask});
            else n_pass++;
            n_chk++;
         end
      end
   endtask

   task automatic test_single_ball();
      int extra = 0;
      tick(0, 1, '0);
      tick(1, 0, '0);
      for (int c = 0; c < 19; c++) tick(0, 0, (c >= 4 && c < 14) ? 8'h08 : 8'h00);
      tick(1, 0, '0);
      if (bus.increaseScore !== 1'b1 || bus.pocketedMask !== 8'h08 || bus.whiteBallRespawn !== 1'b0)
         $display("FAIL single_first_pulse got inc=%b mask=%h resp=%b exp inc=1 mask=08 resp=0", bus.increaseScore, bus.pocketedMask, bus.whiteBallRespawn);
      else n_pass++;
      n_chk++;
      tick(0, 0, '0);
      if (bus.increaseScore !== 1'b0)
         $display("FAIL single_pulse_width got inc=%b exp=0", bus.increaseScore);
      else n_pass++;
      n_chk++;
      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < 16; c++) begin
            tick(c == 0, 0, (c > 2) ? 8'h08 : 8'h00);
            extra += bus.increaseScore;
            if ({bus.increaseScore, bus.decreaseScore, bus.whiteBallRespawn, bus.allPocketed, bus.pocketedMask} !== {e_inc, e_dec, e_resp, e_all, e_mask})
               $display("FAIL single_repeat cyc=%0d got=%b exp=%b", cyc, {bus.increaseScore, bus.decreaseScore, bus.whiteBallRespawn, bus.allPocketed, bus.pocketedMask}, {e_inc, e_dec, e_resp, e_all, e_mask});
            else n_pass++;
            n_chk++;
         end
      end
      if (extra != 0)
         $display("FAIL single_no_rescore got=%0d pulses exp=0", extra);
      else n_pass++;
      n_chk++;
   endtask

   task automatic test_multi_order();
      logic [2:0] got;
      logic [2:0] exp_seq [6];
      exp_seq[0] = {1'b0, PEN, 1'b1};
      exp_seq[1] = 3'b000;
      exp_seq[2] = 3'b100;
      exp_seq[3] = 3'b000;
      exp_seq[4] = 3'b100;
      exp_seq[5] = 3'b000;
      tick(0, 1, '0);
      tick(1, 0, '0);
      for (int c = 0; c < 8; c++) tick(0, 0, (c < 5) ? 8'h25 : 8'h00);
      tick(1, 0, '0);
      for (int t = 0; t < 6; t++) begin
         got = {bus.increaseScore, bus.decreaseScore, bus.whiteBallRespawn};
         if (got !== exp_seq[t] || (bus.increaseScore & bus.decreaseScore) !== 1'b0)
            $display("FAIL multi_order T+%0d got=%b exp=%b (inc,dec,resp)", t + 1, got, exp_seq[t]);
         else n_pass++;
         n_chk++;
         if ({bus.increaseScore, bus.decreaseScore, bus.whiteBallRespawn, bus.allPocketed, bus.pocketedMask} !== {e_inc, e_dec, e_resp, e_all, e_mask})
            $display("FAIL multi_model cyc=%0d got=%b exp=%b", cyc, {bus.increaseScore, bus.decreaseScore, bus.whiteBallRespawn, bus.allPocketed, bus.pocketedMask}, {e_inc, e_dec, e_resp, e_all, e_mask});
         else n_pass++;
         n_chk++;
         tick(0, 0, '0);
      end
      if (bus.pocketedMask !== 8'h24)
         $display("FAIL multi_mask got=%h exp=24", bus.pocketedMask);
      else n_pass++;
      n_chk++;
   endtask

   task automatic test_white_rearm();
      bit pat [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      int n_resp = 0;
      int n_dec = 0;
      tick(0, 1, '0);
      for (int f = 0; f < 6; f++) begin
         for (int c = 0; c < 16; c++) begin
            tick(c == 0, 0, pat[f] ? 8'h01 : 8'h00);
            n_resp += bus.whiteBallRespawn;
            n_dec  += bus.decreaseScore;
            if ({bus.increaseScore, bus.decreaseScore, bus.whiteBallRespawn, bus.allPocketed, bus.pocketedMask} !== {e_inc, e_dec, e_resp, e_all, e_mask})
               $display("FAIL white_model cyc=%0d got=%b exp=%b", cyc, {bus.increaseScore, bus.decreaseScore, bus.whiteBallRespawn, bus.allPocketed, bus.pocketedMask}, {e_inc, e_dec, e_resp, e_all, e_mask});
            else n_pass++;
            n_chk++;
         end
      end
      if (n_resp != 2 || n_dec != (PEN ? 2 : 0))
         $display("FAIL white_counts got resp=%0d dec=%0d exp resp=2 dec=%0d", n_resp, n_dec, PEN ? 2 : 0);
      else n_pass++;
      n_chk++;
   endtask

   task automatic test_all_pocketed();
      bit [N-1:0] one = 1;
      tick(0, 1, '0);
      for (int b = 1; b < N; b++) begin
         tick(1, 0, '0);
         for (int c = 0; c < 11; c++) tick(0, 0, (c < 5) ? (one << b) : '0);
      end
      if (bus.allPocketed !== 1'b0)
         $display("FAIL all_early got=%b exp=0", bus.allPocketed);
      else n_pass++;
      n_chk++;
      tick(1, 0, '0);
      if (bus.allPocketed !== 1'b1 || bus.pocketedMask !== 8'hFE)
         $display("FAIL all_set got all=%b mask=%h exp all=1 mask=fe", bus.allPocketed, bus.pocketedMask);
      else n_pass++;
      n_chk++;
      tick(0, 1, '0);
      if (bus.allPocketed !== 1'b0 || bus.pocketedMask !== 8'h00)
         $display("FAIL all_newgame got all=%b mask=%h exp all=0 mask=00", bus.allPocketed, bus.pocketedMask);
      else n_pass++;
      n_chk++;
   endtask

   task automatic test_reset_mid_issue();
      int n_pulse = 0;
      tick(0, 1, '0);
      tick(1, 0, '0);
      for (int c = 0; c < 5; c++) tick(0, 0, (c < 3) ? 8'h0E : 8'h00);
      tick(1, 0, '0);
      #2 resetN = 1'b0;
      #1;
      model_reset();
      if ({bus.increaseScore, bus.decreaseScore, bus.whiteBallRespawn, bus.allPocketed, bus.pocketedMask} !== 12'h000)
         $display("FAIL reset_async got=%b exp=0", {bus.increaseScore, bus.decreaseScore, bus.whiteBallRespawn, bus.allPocketed, bus.pocketedMask});
      else n_pass++;
      n_chk++;
      tick(0, 0, '0);
      tick(0, 0, '0);
      resetN = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick(0, 0, '0);
         n_pulse += bus.increaseScore + bus.decreaseScore + bus.whiteBallRespawn;
      end
      if (n_pulse != 0 || bus.pocketedMask !== 8'h00)
         $display("FAIL reset_discard got pulses=%0d mask=%h exp pulses=0 mask=00", n_pulse, bus.pocketedMask);
      else n_pass++;
      n_chk++;
   endtask

   task automatic test_random();
      int next_sof = 0;
      bit [N-1:0] bip;
      bit ng;
      tick(0, 1, '0);
      for (int c = 0; c < 1500; c++) begin
         bip = '0;
         for (int i = 0; i < N; i++) bip[i] = ($urandom_range(0, 11) == 0);
         ng = ($urandom_range(0, 299) == 0);
         if (c == next_sof) next_sof = c + $urandom_range(10, 24);
         tick(c == next_sof - 0 && c != 0 ? 1'b0 : 1'b0, ng, bip);
         if ({bus.increaseScore, bus.decreaseScore, bus.whiteBallRespawn, bus.allPocketed, bus.pocketedMask} !== {e_inc, e_dec, e_resp, e_all, e_mask})
            $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, {bus.increaseScore, bus.decreaseScore, bus.whiteBallRespawn, bus.allPocketed, bus.pocketedMask}, {e_inc, e_dec, e_resp, e_all, e_mask});
         else n_pass++;
         n_chk++;
      end
   endtask

   task automatic test_random_frames();
      int gap;
      bit [N-1:0] bip;
      bit ng;
      tick(0, 1, '0);
      for (int f = 0; f < 80; f++) begin
         gap = $urandom_range(6, 24);
         for (int c = 0; c < gap; c++) begin
            bip = '0;
            for (int i = 0; i < N; i++) bip[i] = ($urandom_range(0, 15) == 0);
            ng = ($urandom_range(0, 399) == 0);
            tick(c == 0, ng, bip);
            if ({bus.increaseScore, bus.decreaseScore, bus.whiteBallRespawn, bus.allPocketed, bus.pocketedMask} !== {e_inc, e_dec, e_resp, e_all, e_mask})
               $display("FAIL random_frames cyc=%0d got=%b exp=%b", cyc, {bus.increaseScore, bus.decreaseScore, bus.whiteBallRespawn, bus.allPocketed, bus.pocketedMask}, {e_inc, e_dec, e_resp, e_all, e_mask});
            else n_pass++;
            n_chk++;
            if ((bus.increaseScore & bus.decreaseScore) !== 1'b0)
               $display("FAIL random_exclusive cyc=%0d got inc&dec=1 exp=0", cyc);
            else n_pass++;
            n_chk++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_ball();
      test_multi_order();
      test_white_rearm();
      test_all_pocketed();
      test_reset_mid_issue();
      test_random();
      test_random_frames();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
